// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search used by the AXI-Stream packet arbiter.
// Supports up to ARB_MAX_PORTS requesters.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_PORTS = 32;
  localparam int ARB_IDX_W     = 5;

  // Returns the first set bit of req searching upward from ptr+1, wrapping at nports;
  // the pointer itself is the last candidate so a lone requester always wins.
  function automatic int rr_next(
    input logic [ARB_MAX_PORTS-1:0] req,
    input int                       ptr,
    input int                       nports
  );
    int                   cand;
    logic [ARB_IDX_W-1:0] sel;
    logic                 found;
    rr_next = ptr;
    found   = 1'b0;
    for (int k = 1; k <= ARB_MAX_PORTS; k++) begin
      if (k <= nports) begin
        cand = (ptr + k) % nports;
        sel  = cand[ARB_IDX_W-1:0];
        if (!found && req[sel]) begin
          rr_next = cand;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate past ptr, priority-encode, un-rotate.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int P_NUM_PORTS = 4,
  localparam int P_ID_WIDTH  = $clog2(P_NUM_PORTS)
) (
  input  logic [P_NUM_PORTS-1:0] req,
  input  logic [P_ID_WIDTH-1:0]  ptr,
  output logic [P_ID_WIDTH-1:0]  gnt_id,
  output logic                   gnt_vld
);

  logic [ARB_MAX_PORTS-1:0] w_req;

  assign w_req   = ARB_MAX_PORTS'(req);
  assign gnt_id  = P_ID_WIDTH'(rr_next(w_req, int'(ptr), P_NUM_PORTS));
  assign gnt_vld = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin AXI-Stream arbiter with a full-throughput output register.
// Optional AXIS_ARB_SRC_ID_EN adds m_axis_tid carrying the source port of each beat.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int P_NUM_PORTS  = 4,
  parameter  int P_DATA_WIDTH = 16,
  localparam int P_ID_WIDTH   = $clog2(P_NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [P_NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [P_NUM_PORTS-1:0]            s_axis_tready,
  input  logic [P_NUM_PORTS*P_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [P_NUM_PORTS-1:0]            s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [P_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                              m_axis_tlast,
`ifdef AXIS_ARB_SRC_ID_EN
  output logic [P_ID_WIDTH-1:0]             m_axis_tid,
`endif
  output logic [P_ID_WIDTH-1:0]             grant_id,
  output logic                              busy
);

  arb_state_t              r_state;
  logic [P_ID_WIDTH-1:0]   r_rr_ptr;
  logic [P_ID_WIDTH-1:0]   r_grant;
  logic                    r_m_valid;
  logic [P_DATA_WIDTH-1:0] r_m_data;
  logic                    r_m_last;
`ifdef AXIS_ARB_SRC_ID_EN
  logic [P_ID_WIDTH-1:0]   r_m_tid;
`endif

  logic [P_ID_WIDTH-1:0]   w_pick_id;
  logic                    w_pick_vld;
  logic                    w_slot_ready;
  logic                    w_accept;
  logic [P_DATA_WIDTH-1:0] w_sel_data;
  logic                    w_sel_last;

  rr_pick #(
    .P_NUM_PORTS(P_NUM_PORTS)
  ) u_pick (
    .req    (s_axis_tvalid),
    .ptr    (r_rr_ptr),
    .gnt_id (w_pick_id),
    .gnt_vld(w_pick_vld)
  );

  // The output slot can take a beat when empty or when it is being drained this cycle.
  assign w_slot_ready = !r_m_valid || m_axis_tready;
  assign w_accept     = (r_state == PKT) && s_axis_tvalid[r_grant] && w_slot_ready;
  assign w_sel_data   = s_axis_tdata[r_grant*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign w_sel_last   = s_axis_tlast[r_grant];

  always_comb begin
    s_axis_tready = '0;
    if (r_state == PKT) begin
      s_axis_tready[r_grant] = w_slot_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= P_ID_WIDTH'(P_NUM_PORTS - 1);
      r_grant   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
`ifdef AXIS_ARB_SRC_ID_EN
      r_m_tid   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_sel_data;
        r_m_last  <= w_sel_last;
`ifdef AXIS_ARB_SRC_ID_EN
        r_m_tid   <= r_grant;
`endif
      end else if (m_axis_tready) begin
        r_m_valid <= 1'b0;
      end

      // Grant is locked from arbitration until the tlast beat is accepted.
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_grant <= w_pick_id;
            r_state <= PKT;
          end
        end
        PKT: begin
          if (w_accept && w_sel_last) begin
            r_rr_ptr <= r_grant;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tlast  = r_m_last;
`ifdef AXIS_ARB_SRC_ID_EN
  assign m_axis_tid    = r_m_tid;
`endif
  assign grant_id      = r_grant;
  assign busy          = (r_state == PKT);

endmodule
